adder_seq: RTL and testbench
============================

ADDER_SEQ -- requirements
Module: adder_seq

Interface
- REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (>= 2).
- REQ-002 SHALL have parameter CHUNK, default 2, bits added per cycle; WIDTH % CHUNK == 0, else elaboration error.
- REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
- REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
- REQ-005 SHALL have port in_valid, input, 1, operands and mode valid.
- REQ-006 SHALL have port in_ready, output, 1, block can accept operands.
- REQ-007 SHALL have port a, input, WIDTH, operand A.
- REQ-008 SHALL have port b, input, WIDTH, operand B.
- REQ-009 SHALL have port sub, input, 1, 0 = A+B, 1 = A-B.
- REQ-010 SHALL have port out_valid, output, 1, result valid.
- REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
- REQ-012 SHALL have port out, output, WIDTH+1, {carry, sum}; same packing as the existing 8-bit ripple adder.
- REQ-013 SHALL have port ovf, output, 1, signed two's-complement overflow.

Function
- REQ-014 SHALL implement FSM states IDLE, RUN, DONE; N = WIDTH/CHUNK.
- REQ-015 IDLE: in_ready=1; on in_valid&&in_ready, SHALL capture a, b, sub; initialise carry = sub; clear chunk index; go to RUN.
- REQ-016 RUN: in_ready=0; each cycle SHALL add chunk i of A to chunk i of (sub ? ~B : B) plus carry, LSB chunk first, and store sum chunk and carry-out.
- REQ-017 After chunk N-1 is processed SHALL go to DONE; out_valid rises exactly N clock edges after the accepting edge.
- REQ-018 DONE: out_valid=1; out, ovf SHALL remain stable until out_valid&&out_ready; then return to IDLE on the same edge.
- REQ-019 in_ready SHALL be 0 in RUN and DONE; no same-cycle pass-through from DONE to accepting new operands (one IDLE cycle minimum).
- REQ-020 Input operands SHALL be ignored outside IDLE; changes to a, b, sub after acceptance SHALL not affect the result.
- REQ-021 out[WIDTH] SHALL be carry-out for add, not-borrow for subtract (1 when A >= B unsigned).
- REQ-022 ovf SHALL be 1 when operand sign bits (A, effective B) agree and result sign differs; WIDTH bits wrap modulo 2^WIDTH.
- REQ-023 out_valid SHALL be 0 in IDLE and RUN; out, ovf hold the last result outside DONE.

Reset
- REQ-024 rst_n low SHALL asynchronously force IDLE, in_ready=1 after release, out_valid=0, out=0, ovf=0, chunk index 0, carry 0.
- REQ-025 Reset asserted mid-RUN or in DONE SHALL discard the operation; no out_valid pulse after release without a new accept.

Configuration
- REQ-026 Macro ADDER_SEQ_SAT_EN defined: when ovf=1, out[WIDTH-1:0] SHALL be signed-saturated (max positive if A non-negative, else min negative); out[WIDTH] and ovf unchanged.
- REQ-027 Macro ADDER_SEQ_SAT_EN undefined: out[WIDTH-1:0] SHALL be the wrapped result; no saturation logic synthesised.

Verification (WIDTH=8, CHUNK=2)
- REQ-028 a=200, b=100, sub=0 accepted -> out_valid exactly 4 edges later, out=9'h12C, ovf=0.
- REQ-029 a=5, b=7, sub=1 -> out=9'h0FE (carry 0), ovf=0; a=7, b=5, sub=1 -> out=9'h102.
- REQ-030 a=8'h7F, b=8'h01, sub=0 -> ovf=1, out=9'h080 without macro, 9'h07F with ADDER_SEQ_SAT_EN.
- REQ-031 out_ready held 0 for 10 cycles in DONE -> out_valid, out stable, in_ready=0; out_ready=1 -> IDLE next edge.
- REQ-032 rst_n pulsed low during RUN (chunk 2) -> out_valid=0, in_ready=1 after release; next accept a=1, b=1 -> out=9'h002.

Source files
------------

// File: rtl/adder_seq.sv
// Sequential adder/subtractor: CHUNK bits per cycle, WIDTH/CHUNK cycles per operation, valid/ready on both sides.
// Optional ADDER_SEQ_SAT_EN: signed saturation of the sum bits when ovf is set.
module adder_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2) begin : g_width_chk
      $error("adder_seq: WIDTH must be >= 2");
    end
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_chunk_chk
      $error("adder_seq: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;      // effective operand: already inverted for subtract
  logic [WIDTH-1:0]  sum_q;
  logic              carry_q;
  logic [IW-1:0]     idx_q;
  logic [WIDTH:0]    out_q;
  logic              ovf_q;

  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK:0]    chunk_sum;
  logic              last;
  logic [WIDTH-1:0]  full_sum;
  logic              ovf_calc;
  logic [WIDTH-1:0]  result;

  always_comb begin
    a_chunk   = a_q[idx_q*CHUNK +: CHUNK];
    b_chunk   = b_q[idx_q*CHUNK +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    last      = (idx_q == IW'(N - 1));
    full_sum  = sum_q;
    full_sum[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    ovf_calc  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (full_sum[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ADDER_SEQ_SAT_EN
    if (ovf_calc) begin
      result = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      result = full_sum;
    end
`else
    result    = full_sum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        sum_q[idx_q*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
        carry_q <= chunk_sum[CHUNK];
        if (last) begin
          idx_q <= '0;
          out_q <= {chunk_sum[CHUNK], result};
          ovf_q <= ovf_calc;
        end else begin
          idx_q <= idx_q + IW'(1);
        end
      end
    end
  end

  assign out = out_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_adder_seq.sv
// Directed, table-driven bench for adder_seq (WIDTH=8, CHUNK=2); expected values hand-computed.
module tb_adder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  adder_seq #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [8:0] exp_out;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic scramble_inputs();
    logic [31:0] r;
    r   = $urandom;
    a   = r[7:0];
    b   = r[15:8];
    sub = r[16];
  endtask

  // Accepts one operation and returns the number of edges until out_valid.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts, output int lat);
    @(negedge clk);
    chk("accept_in_ready", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op(input logic [8:0] exp_out);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_hs_out_hold", {23'd0, out}, {23'd0, exp_out});
  endtask

  initial begin
    int lat;
    logic [8:0] held;

    vecs[0] = '{8'd200, 8'd100, 1'b0, 9'h12C, 1'b0};
    vecs[1] = '{8'd5,   8'd7,   1'b1, 9'h0FE, 1'b0};
    vecs[2] = '{8'd7,   8'd5,   1'b1, 9'h102, 1'b0};
`ifdef ADDER_SEQ_SAT_EN
    vecs[3] = '{8'h7F,  8'h01,  1'b0, 9'h07F, 1'b1};
    vecs[4] = '{8'h80,  8'h80,  1'b0, 9'h180, 1'b1};
    vecs[5] = '{8'h80,  8'h01,  1'b1, 9'h180, 1'b1};
`else
    vecs[3] = '{8'h7F,  8'h01,  1'b0, 9'h080, 1'b1};
    vecs[4] = '{8'h80,  8'h80,  1'b0, 9'h100, 1'b1};
    vecs[5] = '{8'h80,  8'h01,  1'b1, 9'h17F, 1'b1};
`endif
    vecs[6] = '{8'hFF,  8'h01,  1'b0, 9'h100, 1'b0};
    vecs[7] = '{8'h00,  8'h00,  1'b1, 9'h100, 1'b0};
    vecs[8] = '{8'h55,  8'hAA,  1'b0, 9'h0FF, 1'b0};
    vecs[9] = '{8'h3C,  8'hC3,  1'b1, 9'h079, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out", {23'd0, out}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      chk($sformatf("vec%0d_latency", i), lat, 32'd4);
      chk($sformatf("vec%0d_out", i), {23'd0, out}, {23'd0, vecs[i].exp_out});
      chk($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].exp_ovf});
      chk($sformatf("vec%0d_done_in_ready", i), {31'd0, in_ready}, 32'd0);
      finish_op(vecs[i].exp_out);
    end

    // Backpressure: result held for 10 cycles while inputs toggle and in_valid is asserted.
    start_op(8'h10, 8'h20, 1'b0, lat);
    chk("stall_latency", lat, 32'd4);
    held = 9'h030;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      scramble_inputs();
      @(posedge clk); #1;
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_out", {23'd0, out}, {23'd0, held});
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    finish_op(held);

    // Reset while chunk 2 is in flight: operation discarded.
    @(negedge clk);
    a = 8'h0F; b = 8'h0F; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrun_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrun_rst_out", {23'd0, out}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 8; c++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("midrun_no_stray_valid", seen, 32'd0);
    end
    start_op(8'd1, 8'd1, 1'b0, lat);
    chk("after_rst_latency", lat, 32'd4);
    chk("after_rst_out", {23'd0, out}, 32'h002);
    chk("after_rst_ovf", {31'd0, ovf}, 32'd0);
    finish_op(9'h002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
